// File: rtl/bitmask_set_bit_iterator.sv
// Walks the set bits of an accepted bitmask, lowest first, emitting one one-hot word per output handshake.
// Define BITMASK_SET_BIT_ITERATOR_INDEX_EN to build the binary index encoder; otherwise output_index is tied to 0.
module bitmask_set_bit_iterator #(
    parameter int WORD_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_data,
    output logic                   output_last,
    output logic [INDEX_WIDTH-1:0] output_index
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [WORD_WIDTH-1:0] remaining;
    logic [WORD_WIDTH-1:0] next_remaining;

    logic [WORD_WIDTH-1:0] lowered;
    logic [WORD_WIDTH-1:0] thermo;
    logic [WORD_WIDTH-1:0] onehot;
    logic [WORD_WIDTH-1:0] rest;
    logic                  is_last;

    // Rightmost-1 isolation: thermo covers the lowest set bit and every zero below it.
    assign lowered = remaining - {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    assign thermo  = remaining ^ lowered;
    assign onehot  = thermo & remaining;
    assign rest    = remaining & lowered;
    assign is_last = (rest == '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= next_state;
            remaining <= next_remaining;
        end
    end

    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        input_ready    = 1'b0;
        output_valid   = 1'b0;
        output_data    = '0;
        output_last    = 1'b0;

        case (state)
            IDLE: begin
                input_ready = 1'b1;
                if (input_valid && (input_data != '0)) begin
                    next_remaining = input_data;
                    next_state     = BUSY;
                end
            end
            BUSY: begin
                output_valid = 1'b1;
                output_data  = onehot;
                output_last  = is_last;
                input_ready  = output_ready && is_last;
                if (output_ready) begin
                    next_remaining = rest;
                    if (is_last) begin
                        // A word offered alongside the final bit is loaded immediately, so no bubble appears.
                        if (input_valid && (input_data != '0)) begin
                            next_remaining = input_data;
                            next_state     = BUSY;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            default: begin
                next_state     = IDLE;
                next_remaining = '0;
            end
        endcase
    end

`ifdef BITMASK_SET_BIT_ITERATOR_INDEX_EN
    logic [INDEX_WIDTH-1:0] index_enc;

    // Each index bit is the OR of the one-hot positions whose binary address has that bit set.
    always_comb begin
        index_enc = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            for (int b = 0; b < INDEX_WIDTH; b++) begin
                if (i[b]) begin
                    index_enc[b] = index_enc[b] | onehot[i];
                end
            end
        end
    end

    assign output_index = output_valid ? index_enc : '0;
`else
    assign output_index = '0;
`endif

endmodule

// File: tb/tb_bitmask_set_bit_iterator.sv
// Directed, table-driven bench for bitmask_set_bit_iterator at WORD_WIDTH=8.
module tb_bitmask_set_bit_iterator;

    localparam int W  = 8;
    localparam int IW = 3;
`ifdef BITMASK_SET_BIT_ITERATOR_INDEX_EN
    localparam bit INDEX_EN = 1'b1;
`else
    localparam bit INDEX_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear;
    logic          input_valid;
    logic          input_ready;
    logic [W-1:0]  input_data;
    logic          output_valid;
    logic          output_ready;
    logic [W-1:0]  output_data;
    logic          output_last;
    logic [IW-1:0] output_index;

    int testsRun  = 0;
    int testsFail = 0;

    bitmask_set_bit_iterator #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) dut (
        .clock        (clock),
        .clear        (clear),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last),
        .output_index (output_index)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         clr;
        logic         iv;
        logic [W-1:0] idata;
        logic         ordy;
        logic         expIr;
        logic         expOv;
        logic [W-1:0] expOd;
        logic         expOl;
        int           expPos;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic iv, logic [W-1:0] idata, logic ordy,
                                logic expIr, logic expOv, logic [W-1:0] expOd,
                                logic expOl, int expPos);
        vec_t v;
        v.clr = clr; v.iv = iv; v.idata = idata; v.ordy = ordy;
        v.expIr = expIr; v.expOv = expOv; v.expOd = expOd; v.expOl = expOl; v.expPos = expPos;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        clear        = v.clr;
        input_valid  = v.iv;
        input_data   = v.idata;
        output_ready = v.ordy;
    endtask

    task automatic checkBit(input string name, input int idx, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [IW-1:0] expIdx;
        expIdx = INDEX_EN ? IW'(v.expPos) : '0;
        checkBit("input_ready", idx, input_ready, v.expIr);
        checkBit("output_valid", idx, output_valid, v.expOv);
        checkBit("output_last", idx, output_last, v.expOl);
        testsRun++;
        if (output_data !== v.expOd) begin
            testsFail++;
            $display("[TB] FAIL output_data step %0d: got %h, expected %h", idx, output_data, v.expOd);
        end
        testsRun++;
        if (output_index !== expIdx) begin
            testsFail++;
            $display("[TB] FAIL output_index step %0d: got %0d, expected %0d", idx, output_index, expIdx);
        end
    endtask

    task automatic runStep(input vec_t v, input int idx);
        @(negedge clock);
        applyStimulus(v);
        #1;
        checkOutput(v, idx);
    endtask

    initial begin
        clear        = 1'b1;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;
        repeat (2) @(posedge clock);

        // Fields: clr, iv, idata, ordy | input_ready, output_valid, output_data, output_last, index
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // 0x58 with output_ready held high
        vecs.push_back(mk(0, 1, 8'h58, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h08, 0, 3));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h10, 0, 4));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h40, 1, 6));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // zero word accepted and dropped
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // 0x81 with three stalled cycles
        vecs.push_back(mk(0, 1, 8'h81, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h80, 1, 7));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // 0x80 then 0x01 back to back
        vecs.push_back(mk(0, 1, 8'h80, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1, 1, 1, 8'h80, 1, 7));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h01, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // last bit stalled: offered word must not be taken
        vecs.push_back(mk(0, 1, 8'h04, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 1, 8'h04, 1, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h04, 1, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // zero word alongside final bit returns to IDLE
        vecs.push_back(mk(0, 1, 8'h20, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'h20, 1, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // full word 0xFF
        vecs.push_back(mk(0, 1, 8'hFF, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h02, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h04, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h08, 0, 3));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h10, 0, 4));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h20, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h40, 0, 6));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h80, 1, 7));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));

        foreach (vecs[i]) runStep(vecs[i], i);

        // Clear mid-word: 0xFF, one handshake, then clear with a competing input offer
        runStep(mk(0, 1, 8'hFF, 1, 1, 0, 8'h00, 0, 0), 100);
        runStep(mk(0, 0, 8'h00, 1, 0, 1, 8'h01, 0, 0), 101);
        runStep(mk(1, 1, 8'h10, 1, 0, 1, 8'h02, 0, 1), 102);
        runStep(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0), 103);
        runStep(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0), 104);
        runStep(mk(0, 1, 8'h02, 1, 1, 0, 8'h00, 0, 0), 105);
        runStep(mk(0, 0, 8'h00, 1, 1, 1, 8'h02, 1, 1), 106);
        runStep(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0), 107);

        // Clear while idle with a valid offer: the offer is discarded
        runStep(mk(1, 1, 8'h0C, 1, 1, 0, 8'h00, 0, 0), 110);
        runStep(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0), 111);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
